// File: rtl/tmds_timing_gen.sv
// 720p60 transmit raster generator: syncs, data enable, lead-timed FIFO read strobe,
// position/active counters and optional genlock of the frame start to an external vsync.
module tmds_timing_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   RD_LEAD  = 2
) (
    input  logic        tx0_pclk,
    input  logic        rstbtn_n,
    input  logic        lock_en,
    input  logic        ext_vsync,
    output logic        tx0_hsync,
    output logic        tx0_vsync,
    output logic        tx0_de,
    output logic        rd_en,
    output logic [10:0] h_pos,
    output logic [10:0] v_pos,
    output logic [10:0] video_hcnt,
    output logic [10:0] video_vcnt,
    output logic [11:0] index,
    output logic        frame_start,
    output logic        locked
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] HS_END   = 11'(H_SYNC);
    localparam logic [10:0] VS_END   = 11'(V_SYNC);
    localparam logic [10:0] HA0      = 11'(H_SYNC + H_BP);
    localparam logic [10:0] HA_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] H_MID    = 11'(H_SYNC + H_BP + H_ACTIVE / 2);
    localparam logic [10:0] RD_START = 11'(H_SYNC + H_BP - RD_LEAD);
    localparam logic [10:0] RD_END   = 11'(H_SYNC + H_BP + H_ACTIVE - RD_LEAD);
    localparam logic [10:0] VA0      = 11'(V_SYNC + V_BP);
    localparam logic [10:0] VA_END   = 11'(V_SYNC + V_BP + V_ACTIVE);

    logic [10:0] h_q, h_d, v_q, v_d;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [11:0] index_q, index_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        de_q, de_d, rd_q, rd_d;
    logic        fs_q, fs_d, locked_q, locked_d;
    logic        ext_q, ext_d, ext_prev_q, ext_prev_d;
    logic        genlock_edge, at_last, v_act;

    // Every output is decoded from the next position so it lands aligned with h_pos/v_pos.
    always_comb begin
        genlock_edge = lock_en && ext_q && !ext_prev_q;
        at_last      = (h_q == H_LAST) && (v_q == V_LAST);
        ext_d        = ext_vsync;
        ext_prev_d   = ext_q;

        h_d = h_q + 11'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = 11'd0;
            v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
        end
        if (genlock_edge) begin
            h_d = 11'd0;
            v_d = 11'd0;
        end

        v_act   = (v_d >= VA0) && (v_d < VA_END);
        hsync_d = (h_d < HS_END) ? HS_POL : ~HS_POL;
        vsync_d = (v_d < VS_END) ? VS_POL : ~VS_POL;
        de_d    = v_act && (h_d >= HA0) && (h_d < HA_END);
        rd_d    = v_act && (h_d >= RD_START) && (h_d < RD_END);
        hcnt_d  = de_d ? (h_d - HA0) : 11'd0;
        vcnt_d  = v_act ? (v_d - VA0) : 11'd0;
        fs_d    = (h_d == 11'd0) && (v_d == 11'd0);

        // Two half-line steps per active line; restart on the first active line.
        index_d = index_q;
        if (v_act && (h_d == HA0)) begin
            index_d = (v_d == VA0) ? 12'd0 : index_q + 12'd1;
        end else if (v_act && (h_d == H_MID)) begin
            index_d = index_q + 12'd1;
        end

        locked_d = locked_q;
        if (!lock_en) begin
            locked_d = 1'b0;
        end else if (genlock_edge) begin
            locked_d = at_last;
        end
    end

    always_ff @(posedge tx0_pclk) begin
        if (rstbtn_n) begin
            h_q        <= H_LAST;
            v_q        <= V_LAST;
            hsync_q    <= ~HS_POL;
            vsync_q    <= ~VS_POL;
            de_q       <= 1'b0;
            rd_q       <= 1'b0;
            hcnt_q     <= 11'd0;
            vcnt_q     <= 11'd0;
            index_q    <= 12'd0;
            fs_q       <= 1'b0;
            locked_q   <= 1'b0;
            ext_q      <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            rd_q       <= rd_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            index_q    <= index_d;
            fs_q       <= fs_d;
            locked_q   <= locked_d;
            ext_q      <= ext_d;
            ext_prev_q <= ext_prev_d;
        end
    end

    assign h_pos       = h_q;
    assign v_pos       = v_q;
    assign tx0_hsync   = hsync_q;
    assign tx0_vsync   = vsync_q;
    assign tx0_de      = de_q;
    assign rd_en       = rd_q;
    assign video_hcnt  = hcnt_q;
    assign video_vcnt  = vcnt_q;
    assign index       = index_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_tmds_timing_gen.sv
// Bench for tmds_timing_gen on a shrunken raster: cycle scoreboard from a behavioural
// model, constant spot-check table, and directed genlock/reset sequences.
module tb_tmds_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 3;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 6;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam int RD_LEAD  = 2;
    localparam int HT       = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int VT       = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HA0      = H_SYNC + H_BP;
    localparam int VA0      = V_SYNC + V_BP;
    localparam int FRAME    = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lock_en = 1'b0;
    logic ext_vsync = 1'b0;

    logic        hsync, vsync, de, rd_en, frame_start, locked;
    logic [10:0] h_pos, v_pos, hcnt, vcnt;
    logic [11:0] index;
    logic        n_hsync, n_vsync, n_de, n_rd_en, n_fs, n_locked;
    logic [10:0] n_h_pos, n_v_pos, n_hcnt, n_vcnt;
    logic [11:0] n_index;

    always #5 clk = ~clk;

    tmds_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LEAD(RD_LEAD)
    ) dut (
        .tx0_pclk(clk), .rstbtn_n(rst), .lock_en(lock_en), .ext_vsync(ext_vsync),
        .tx0_hsync(hsync), .tx0_vsync(vsync), .tx0_de(de), .rd_en(rd_en),
        .h_pos(h_pos), .v_pos(v_pos), .video_hcnt(hcnt), .video_vcnt(vcnt),
        .index(index), .frame_start(frame_start), .locked(locked)
    );

    tmds_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LEAD(RD_LEAD)
    ) dut_n (
        .tx0_pclk(clk), .rstbtn_n(rst), .lock_en(lock_en), .ext_vsync(ext_vsync),
        .tx0_hsync(n_hsync), .tx0_vsync(n_vsync), .tx0_de(n_de), .rd_en(n_rd_en),
        .h_pos(n_h_pos), .v_pos(n_v_pos), .video_hcnt(n_hcnt), .video_vcnt(n_vcnt),
        .index(n_index), .frame_start(n_fs), .locked(n_locked)
    );

    typedef struct {
        int h, v, hs, vs, de, rd, hcnt, vcnt, idx, fs, locked;
    } exp_t;

    typedef struct {
        int h, v, hs, vs, de, rd, hcnt, vcnt, idx, fs;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];

    int checks = 0;
    int errors = 0;
    int mh, mv, mindex, mlocked, me1, me2;

    task automatic checkValue(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Behavioural raster model, advanced once per clock with the inputs of that cycle.
    task automatic modelStep(input bit r, input bit lk, input bit ex);
        bit edge_seen, natural, vact;
        if (r) begin
            mh = HT - 1; mv = VT - 1; mindex = 0; mlocked = 0; me1 = 0; me2 = 0;
        end else begin
            edge_seen = lk && (me1 == 1) && (me2 == 0);
            natural   = (mh == HT - 1) && (mv == VT - 1);
            if (edge_seen) begin
                mh = 0; mv = 0;
            end else begin
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end
            end
            if (!lk) mlocked = 0;
            else if (edge_seen) mlocked = natural ? 1 : 0;
            vact = (mv >= VA0) && (mv < VA0 + V_ACTIVE);
            if (vact && mh == HA0) mindex = (mv == VA0) ? 0 : mindex + 1;
            else if (vact && mh == HA0 + H_ACTIVE / 2) mindex++;
            me2 = me1;
            me1 = ex;
        end
    endtask

    function automatic exp_t mkExp();
        exp_t e;
        bit vact;
        vact     = (mv >= VA0) && (mv < VA0 + V_ACTIVE);
        e.h      = mh;
        e.v      = mv;
        e.hs     = (mh < H_SYNC) ? 1 : 0;
        e.vs     = (mv < V_SYNC) ? 1 : 0;
        e.de     = (vact && mh >= HA0 && mh - HA0 < H_ACTIVE) ? 1 : 0;
        e.rd     = (vact && mh + RD_LEAD >= HA0 && mh + RD_LEAD < HA0 + H_ACTIVE) ? 1 : 0;
        e.hcnt   = e.de ? mh - HA0 : 0;
        e.vcnt   = vact ? mv - VA0 : 0;
        e.idx    = mindex;
        e.fs     = (mh == 0 && mv == 0) ? 1 : 0;
        e.locked = mlocked;
        return e;
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        checkValue("h_pos", h_pos, e.h);
        checkValue("v_pos", v_pos, e.v);
        checkValue("hsync", hsync, e.hs);
        checkValue("vsync", vsync, e.vs);
        checkValue("de", de, e.de);
        checkValue("rd_en", rd_en, e.rd);
        checkValue("video_hcnt", hcnt, e.hcnt);
        checkValue("video_vcnt", vcnt, e.vcnt);
        checkValue("index", index, e.idx);
        checkValue("frame_start", frame_start, e.fs);
        checkValue("locked", locked, e.locked);
        checkValue("neg_hsync", n_hsync, 1 - e.hs);
        checkValue("neg_vsync", n_vsync, 1 - e.vs);
        checkValue("neg_h_pos", n_h_pos, e.h);
        checkValue("neg_v_pos", n_v_pos, e.v);
        checkValue("neg_de", n_de, e.de);
        checkValue("neg_rd_en", n_rd_en, e.rd);
        checkValue("neg_hcnt", n_hcnt, e.hcnt);
        checkValue("neg_vcnt", n_vcnt, e.vcnt);
        checkValue("neg_index", n_index, e.idx);
        checkValue("neg_fs", n_fs, e.fs);
        checkValue("neg_locked", n_locked, e.locked);
    endtask

    task automatic applyStimulus(input bit r, input bit lk, input bit ex);
        rst       = r;
        lock_en   = lk;
        ext_vsync = ex;
        modelStep(r, lk, ex);
        sb.push_back(mkExp());
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runUntil(input int th, input int tv, input bit lk);
        int n = 0;
        while (!(mh == th && mv == tv) && n < 2 * FRAME) begin
            applyStimulus(1'b0, lk, 1'b0);
            n++;
        end
        checkValue("reach_h", h_pos, th);
        checkValue("reach_v", v_pos, tv);
    endtask

    initial begin
        int fidx, de_cnt, rd_cnt, hs_cnt, vs_cnt, fs_cnt;

        tbl[0]  = '{0, 0, 1, 1, 0, 0, 0, 0, 11, 1};
        tbl[1]  = '{3, 1, 1, 1, 0, 0, 0, 0, 11, 0};
        tbl[2]  = '{4, 2, 0, 0, 0, 0, 0, 0, 11, 0};
        tbl[3]  = '{9, 4, 0, 0, 0, 0, 0, 0, 11, 0};
        tbl[4]  = '{17, 5, 0, 0, 1, 1, 7, 0, 0, 0};
        tbl[5]  = '{18, 5, 0, 0, 1, 1, 8, 0, 1, 0};
        tbl[6]  = '{8, 6, 0, 0, 0, 1, 0, 1, 1, 0};
        tbl[7]  = '{9, 6, 0, 0, 0, 1, 0, 1, 1, 0};
        tbl[8]  = '{10, 6, 0, 0, 1, 1, 0, 1, 2, 0};
        tbl[9]  = '{23, 6, 0, 0, 1, 1, 13, 1, 3, 0};
        tbl[10] = '{24, 6, 0, 0, 1, 0, 14, 1, 3, 0};
        tbl[11] = '{25, 6, 0, 0, 1, 0, 15, 1, 3, 0};
        tbl[12] = '{26, 6, 0, 0, 0, 0, 0, 1, 3, 0};
        tbl[13] = '{10, 10, 0, 0, 1, 1, 0, 5, 10, 0};
        tbl[14] = '{28, 10, 0, 0, 0, 0, 0, 5, 11, 0};
        tbl[15] = '{10, 11, 0, 0, 0, 0, 0, 0, 11, 0};

        mh = HT - 1; mv = VT - 1; mindex = 0; mlocked = 0; me1 = 0; me2 = 0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("rst_h_pos", h_pos, HT - 1);
        checkValue("rst_v_pos", v_pos, VT - 1);
        checkValue("rst_hsync", hsync, 0);
        checkValue("rst_vsync", vsync, 0);
        checkValue("rst_neg_hsync", n_hsync, 1);
        checkValue("rst_de", de, 0);
        checkValue("rst_index", index, 0);

        // Two free-running frames from reset release, with the spot table on frame two.
        fidx = -1; de_cnt = 0; rd_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (c == 0) begin
                checkValue("first_h", h_pos, 0);
                checkValue("first_v", v_pos, 0);
                checkValue("first_hsync", hsync, 1);
                checkValue("first_vsync", vsync, 1);
                checkValue("first_fs", frame_start, 1);
            end
            if (mh == 0 && mv == 0) fidx++;
            de_cnt += int'(de);
            rd_cnt += int'(rd_en);
            hs_cnt += int'(hsync);
            vs_cnt += int'(vsync);
            fs_cnt += int'(frame_start);
            if (fidx == 1) begin
                for (int k = 0; k < 16; k++) begin
                    if (tbl[k].h == mh && tbl[k].v == mv) begin
                        checkValue("tbl_hsync", hsync, tbl[k].hs);
                        checkValue("tbl_vsync", vsync, tbl[k].vs);
                        checkValue("tbl_de", de, tbl[k].de);
                        checkValue("tbl_rd_en", rd_en, tbl[k].rd);
                        checkValue("tbl_hcnt", hcnt, tbl[k].hcnt);
                        checkValue("tbl_vcnt", vcnt, tbl[k].vcnt);
                        checkValue("tbl_index", index, tbl[k].idx);
                        checkValue("tbl_fs", frame_start, tbl[k].fs);
                    end
                end
            end
        end
        checkValue("de_cycles", de_cnt, 2 * V_ACTIVE * H_ACTIVE);
        checkValue("rd_cycles", rd_cnt, 2 * V_ACTIVE * H_ACTIVE);
        checkValue("hsync_cycles", hs_cnt, 2 * VT * H_SYNC);
        checkValue("vsync_cycles", vs_cnt, 2 * V_SYNC * HT);
        checkValue("frame_starts", fs_cnt, 2);

        // Genlock: mid-frame edge jumps, the edge one frame later coincides with the wrap.
        runUntil(15, 8, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkValue("lock_jump_h", h_pos, 0);
        checkValue("lock_jump_v", v_pos, 0);
        checkValue("lock_jump_fs", frame_start, 1);
        checkValue("lock_jump_locked", locked, 0);
        for (int k = 2; k < FRAME; k++) applyStimulus(1'b0, 1'b1, (k < 50) ? 1'b1 : 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkValue("lock_pre_h", h_pos, HT - 1);
        checkValue("lock_pre_v", v_pos, VT - 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkValue("lock_wrap_h", h_pos, 0);
        checkValue("lock_wrap_v", v_pos, 0);
        checkValue("lock_wrap_fs", frame_start, 1);
        checkValue("lock_wrap_locked", locked, 1);
        for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkValue("lock_hold_locked", locked, 1);

        // Genlock disabled: toggling ext_vsync must not disturb the raster.
        for (int k = 0; k < 120; k++) applyStimulus(1'b0, 1'b0, ((k / 4) % 2) == 1);
        checkValue("unlock_locked", locked, 0);

        // Reset pulse in the middle of an active line.
        runUntil(20, 7, 1'b0);
        checkValue("pre_rst_de", de, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkValue("midrst_de", de, 0);
        checkValue("midrst_rd_en", rd_en, 0);
        checkValue("midrst_hsync", hsync, 0);
        checkValue("midrst_vsync", vsync, 0);
        checkValue("midrst_hcnt", hcnt, 0);
        checkValue("midrst_vcnt", vcnt, 0);
        checkValue("midrst_index", index, 0);
        checkValue("midrst_h", h_pos, HT - 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkValue("post_rst_fs", frame_start, 1);
        for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
